ram_port_arbiter: RTL and testbench
===================================

RAM_PORT_ARBITER -- requirements
Module: ram_port_arbiter

Interface
REQ-001 The block SHALL provide the following parameters:
- ADDRESS_WIDTH, default 32, byte address width.
- BYTES, default 4, byte lanes per word.
- DATA_WIDTH, default 8*BYTES, word width.
- LOCK_MAX, default 16, maximum consecutive locked ownership cycles when the other master is waiting.

REQ-002 The block SHALL have one clock; reset is synchronous and active-high. Ports are listed below; N is 0 or 1, giving two identical master ports. Format: name, direction, width, meaning.
- clk, in, 1, rising-edge clock for all state.
- rst, in, 1, synchronous active-high reset.
- mN_req, in, 1, master N requests a RAM port-A access this cycle.
- mN_we, in, 1, 1 = write, 0 = read.
- mN_be, in, BYTES, write byte enables.
- mN_addr, in, ADDRESS_WIDTH, byte address.
- mN_wdata, in, DATA_WIDTH, write data.
- mN_lock, in, 1, keep ownership after this access.
- mN_gnt, out, 1, access accepted at this clock edge when mN_req=1.
- mN_rvalid, out, 1, read data valid for master N.
- mN_rdata, out, DATA_WIDTH, read data.
- ram_addr, out, ADDRESS_WIDTH, drives RAM addr1.
- ram_be, out, BYTES, drives RAM be1.
- ram_wdata, out, DATA_WIDTH, drives RAM data_in1.
- ram_we, out, 1, drives RAM we1.
- ram_rdata, in, DATA_WIDTH, RAM data_out1 (registered, 1-cycle latency).

Function
REQ-003 The block SHALL implement three FSM states: IDLE (no owner), OWN0 and OWN1.

REQ-004 In IDLE, the grant SHALL be combinational from mN_req:
- If only one master requests, that master wins.
- If both request, the master selected by the round-robin pointer rr wins.

REQ-005 In OWNx, only master x SHALL be grantable. The other master's gnt SHALL be 0 regardless of its req, except as allowed by REQ-009.

REQ-006 gnt SHALL be asserted only when the corresponding req=1; an access is accepted at the edge where req=1 and gnt=1.

REQ-007 The RAM outputs SHALL be driven as follows:
- ram_addr, ram_be and ram_wdata are combinational muxes of the winner's inputs; they hold master 0's inputs when there is no winner.
- ram_we = winner_gnt & winner_we.
- ram_be SHALL pass through unmodified on reads (the RAM ignores it).

REQ-008 State transitions SHALL occur on an accepted access by master x:
- mx_lock=1: next state is OWNx.
- mx_lock=0: next state is IDLE and rr points to the other master.
- In OWNx, if mx_req=0, the next state is IDLE and rr points to the other master.

REQ-009 A lock counter SHALL bound ownership:
- The counter increments every cycle spent in OWNx and clears on any state change; it saturates at LOCK_MAX.
- When the counter equals LOCK_MAX and the other master's req=1, the block SHALL arbitrate that cycle as IDLE with rr pointing to the other master. The other master wins, and the next state follows REQ-008 for the new winner.

REQ-010 Read response:
- For a read accepted at edge k, mN_rvalid=1 SHALL be asserted for exactly the cycle after edge k, and mN_rdata=ram_rdata in that cycle.
- The target master is captured in a registered response-select bit.
- Writes SHALL NOT produce rvalid.

REQ-011 Both mN_rdata outputs SHALL be wired to ram_rdata; only rvalid is steered. m0_rvalid and m1_rvalid SHALL never both be 1.

REQ-012 Back-to-back accepted reads SHALL yield rvalid on consecutive cycles with no bubble, including when ownership switches between masters.

REQ-013 Arbitration SHALL sustain one accepted access per cycle. No idle cycle is inserted on ownership change.

Reset
REQ-014 While rst=1 at a clock edge:
- state becomes IDLE, rr points to master 0, and the lock counter is 0.
- The response-select bit is 0, and m0_rvalid=m1_rvalid=0 in the following cycle.

REQ-015 A read accepted in the same cycle as rst=1 SHALL produce no rvalid. During a reset cycle the combinational gnt and ram_* outputs may toggle, but the state SHALL still be IDLE after the edge.

Verification
REQ-016 The bench SHALL cover the following directed scenarios:
- Scenario 1: after reset, m0 and m1 read simultaneously at addr 0x0 and 0x4. Expected: m0_gnt=1 and m1_gnt=0 in cycle 1; m1 is granted in cycle 2. m0_rvalid in cycle 2 returns word 0, and m1_rvalid in cycle 3 returns word 1.
- Scenario 2: m1 writes 0xDEADBEEF with be=4'b0011 to addr 0x8, then m0 reads 0x8. Expected: m0_rdata[15:0]=16'hBEEF and the upper bytes keep their prior contents; m1_rvalid stays 0 throughout.
- Scenario 3: m0 issues a locked burst of 4 reads while m1_req=1 continuously. Expected: m1_gnt=0 for the 4 beats; m1 is granted the cycle after m0 accepts with lock=0.
- Scenario 4: LOCK_MAX=4; m0 holds lock indefinitely while m1 requests. Expected: m1_gnt=1 on the cycle the counter reaches 4; m0 regains the grant on the following cycle.
- Scenario 5: m0 read accepted, then rst=1 on the next edge. Expected: m0_rvalid=0 after the reset edge, state is IDLE, and rr=0.
- Scenario 6: both masters issue continuous unlocked reads for 10 cycles. Expected: grants alternate 0,1,0,1..., with exactly 10 rvalid pulses total, 5 per master.

Source files
------------

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: two-master arbiter in front of a single RAM port.
// The grant is combinational, so one access can be accepted every cycle.
// A master may hold ownership with lock, and a counter limits how long it
// can keep the port while the other master is waiting. A read returns its
// data one cycle later, steered to the master that issued it.
module ram_port_arbiter #(
    parameter int unsigned ADDRESS_WIDTH = 32,
    parameter int unsigned BYTES         = 4,
    parameter int unsigned DATA_WIDTH    = 8 * BYTES,
    parameter int unsigned LOCK_MAX      = 16
) (
    input  logic                     clk,
    input  logic                     rst,

    input  logic                     m0_req,
    input  logic                     m0_we,
    input  logic [BYTES-1:0]         m0_be,
    input  logic [ADDRESS_WIDTH-1:0] m0_addr,
    input  logic [DATA_WIDTH-1:0]    m0_wdata,
    input  logic                     m0_lock,
    output logic                     m0_gnt,
    output logic                     m0_rvalid,
    output logic [DATA_WIDTH-1:0]    m0_rdata,

    input  logic                     m1_req,
    input  logic                     m1_we,
    input  logic [BYTES-1:0]         m1_be,
    input  logic [ADDRESS_WIDTH-1:0] m1_addr,
    input  logic [DATA_WIDTH-1:0]    m1_wdata,
    input  logic                     m1_lock,
    output logic                     m1_gnt,
    output logic                     m1_rvalid,
    output logic [DATA_WIDTH-1:0]    m1_rdata,

    output logic [ADDRESS_WIDTH-1:0] ram_addr,
    output logic [BYTES-1:0]         ram_be,
    output logic [DATA_WIDTH-1:0]    ram_wdata,
    output logic                     ram_we,
    input  logic [DATA_WIDTH-1:0]    ram_rdata
);

    localparam int unsigned CNT_W = $clog2(LOCK_MAX + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic               rr_q, rr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic               lock_break;
    logic               arb_idle;
    logic               arb_rr;
    logic               win_vld;
    logic               win_sel;
    logic               win_we;
    logic               win_lock;

    logic               rvalid_q;
    logic               resp_sel_q;

    // State, round-robin pointer and lock counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            rr_q    <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            cnt_q   <= cnt_d;
        end
    end

    // Winner selection, grants and next-state / pointer / counter logic.
    always_comb begin
        state_d    = state_q;
        rr_d       = rr_q;
        cnt_d      = cnt_q;
        win_vld    = 1'b0;
        win_sel    = 1'b0;
        m0_gnt     = 1'b0;
        m1_gnt     = 1'b0;

        // Owner has used up its lock budget and the other master is waiting.
        lock_break = (cnt_q == CNT_W'(LOCK_MAX)) &&
                     (((state_q == OWN0) && m1_req) || ((state_q == OWN1) && m0_req));
        arb_idle   = (state_q == IDLE) || lock_break;
        // Outside IDLE the pointer is forced toward the non-owner.
        arb_rr     = (state_q == IDLE) ? rr_q : (state_q == OWN0);

        if (arb_idle) begin
            if (m0_req && m1_req) begin
                win_vld = 1'b1;
                win_sel = arb_rr;
            end else if (m0_req) begin
                win_vld = 1'b1;
                win_sel = 1'b0;
            end else if (m1_req) begin
                win_vld = 1'b1;
                win_sel = 1'b1;
            end
        end else begin
            case (state_q)
                OWN0: begin
                    win_vld = m0_req;
                    win_sel = 1'b0;
                end
                OWN1: begin
                    win_vld = m1_req;
                    win_sel = 1'b1;
                end
                default: begin
                    win_vld = 1'b0;
                    win_sel = 1'b0;
                end
            endcase
        end

        m0_gnt   = win_vld & ~win_sel;
        m1_gnt   = win_vld &  win_sel;
        win_we   = win_sel ? m1_we   : m0_we;
        win_lock = win_sel ? m1_lock : m0_lock;

        if (win_vld) begin
            if (win_lock) begin
                state_d = win_sel ? OWN1 : OWN0;
            end else begin
                state_d = IDLE;
                rr_d    = ~win_sel;
            end
        end else if (state_q != IDLE) begin
            // Owner stopped requesting: release and point at the other master.
            state_d = IDLE;
            rr_d    = (state_q == OWN0);
        end

        if (state_d != state_q) begin
            cnt_d = '0;
        end else if ((state_q != IDLE) && (cnt_q != CNT_W'(LOCK_MAX))) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // RAM port-A mux; master 0's inputs are presented when nobody wins.
    always_comb begin
        ram_addr  = win_sel ? m1_addr  : m0_addr;
        ram_be    = win_sel ? m1_be    : m0_be;
        ram_wdata = win_sel ? m1_wdata : m0_wdata;
        ram_we    = win_vld & win_we;
    end

    // Read response tracking: one pending read, target master in resp_sel_q.
    always_ff @(posedge clk) begin
        if (rst) begin
            rvalid_q   <= 1'b0;
            resp_sel_q <= 1'b0;
        end else begin
            rvalid_q <= win_vld & ~win_we;
            if (win_vld && !win_we) begin
                resp_sel_q <= win_sel;
            end
        end
    end

    // Both masters see the RAM read data; only rvalid is steered.
    always_comb begin
        m0_rvalid = rvalid_q & ~resp_sel_q;
        m1_rvalid = rvalid_q &  resp_sel_q;
        m0_rdata  = ram_rdata;
        m1_rdata  = ram_rdata;
    end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb_ram_port_arbiter: directed scenarios plus a per-cycle ownership model.
module tb_ram_port_arbiter;

    localparam int unsigned AW        = 32;
    localparam int unsigned NB        = 4;
    localparam int unsigned DW        = 32;
    localparam int unsigned LM        = 4;
    localparam int unsigned MEM_WORDS = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          m0_req, m0_we, m0_lock, m1_req, m1_we, m1_lock;
    logic [NB-1:0] m0_be, m1_be;
    logic [AW-1:0] m0_addr, m1_addr;
    logic [DW-1:0] m0_wdata, m1_wdata;
    logic          m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
    logic [DW-1:0] m0_rdata, m1_rdata;
    logic [AW-1:0] ram_addr;
    logic [NB-1:0] ram_be;
    logic [DW-1:0] ram_wdata;
    logic          ram_we;
    logic [DW-1:0] ram_rdata;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ram_port_arbiter #(
        .ADDRESS_WIDTH(AW), .BYTES(NB), .DATA_WIDTH(DW), .LOCK_MAX(LM)
    ) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_be(m0_be), .m0_addr(m0_addr),
        .m0_wdata(m0_wdata), .m0_lock(m0_lock), .m0_gnt(m0_gnt),
        .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_be(m1_be), .m1_addr(m1_addr),
        .m1_wdata(m1_wdata), .m1_lock(m1_lock), .m1_gnt(m1_gnt),
        .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .ram_addr(ram_addr), .ram_be(ram_be), .ram_wdata(ram_wdata),
        .ram_we(ram_we), .ram_rdata(ram_rdata)
    );

    function automatic logic [DW-1:0] init_word(int i);
        return 32'hA0A0_0000 | 32'(i);
    endfunction

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: actual=%0h required=%0h", name, $time, act, exp);
        end
    endtask

    // RAM stub with registered read; contents reload on reset.
    logic [DW-1:0] ram_mem [MEM_WORDS];
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < MEM_WORDS; i++) ram_mem[i] <= init_word(i);
        end else if (ram_we) begin
            for (int b = 0; b < NB; b++)
                if (ram_be[b]) ram_mem[ram_addr[5:2]][b*8 +: 8] <= ram_wdata[b*8 +: 8];
        end
        ram_rdata <= ram_mem[ram_addr[5:2]];
    end

    // Reference model: owner (-1 none), pointer, cycles held, pending read.
    int            m_owner, m_rr, m_held, m_win, m_next;
    bit            m_on = 1'b0;
    bit            m_forced;
    bit            pv0, pv1;
    logic [DW-1:0] pdata;
    logic [DW-1:0] mmem [MEM_WORDS];
    bit            rq [2];
    bit            lk [2];
    bit            wr [2];
    logic [AW-1:0] ad [2];
    logic [NB-1:0] bs [2];
    logic [DW-1:0] wd [2];

    // Per-cycle compare against the model, then advance it over the next edge.
    always @(negedge clk) begin
        rq[0] = m0_req;  rq[1] = m1_req;
        lk[0] = m0_lock; lk[1] = m1_lock;
        wr[0] = m0_we;   wr[1] = m1_we;
        ad[0] = m0_addr; ad[1] = m1_addr;
        bs[0] = m0_be;   bs[1] = m1_be;
        wd[0] = m0_wdata; wd[1] = m1_wdata;
        if (m_on) begin
            check("model_m0_rvalid", m0_rvalid, pv0);
            check("model_m1_rvalid", m1_rvalid, pv1);
            check("rvalid_exclusive", m0_rvalid & m1_rvalid, 0);
            if (pv0) check("model_m0_rdata", m0_rdata, pdata);
            if (pv1) check("model_m1_rdata", m1_rdata, pdata);
        end
        if (rst) begin
            m_on = 1'b1; m_owner = -1; m_rr = 0; m_held = 0; pv0 = 0; pv1 = 0;
            for (int i = 0; i < MEM_WORDS; i++) mmem[i] = init_word(i);
        end else if (m_on) begin
            m_forced = (m_owner >= 0) && (m_held >= LM) && rq[1 - m_owner];
            m_win = -1;
            if (m_owner < 0 || m_forced) begin
                if (rq[0] && rq[1]) m_win = m_forced ? (1 - m_owner) : m_rr;
                else if (rq[0])     m_win = 0;
                else if (rq[1])     m_win = 1;
            end else if (rq[m_owner]) begin
                m_win = m_owner;
            end
            check("model_m0_gnt", m0_gnt, m_win == 0);
            check("model_m1_gnt", m1_gnt, m_win == 1);
            check("model_ram_we", ram_we, (m_win >= 0) && wr[m_win]);
            if (m_win >= 0) begin
                check("model_ram_addr", ram_addr, ad[m_win]);
                check("model_ram_be", ram_be, bs[m_win]);
                check("model_ram_wdata", ram_wdata, wd[m_win]);
            end
            pv0 = (m_win == 0) && !wr[0];
            pv1 = (m_win == 1) && !wr[1];
            if (m_win >= 0) begin
                pdata = mmem[ad[m_win][5:2]];
                if (wr[m_win])
                    for (int b = 0; b < NB; b++)
                        if (bs[m_win][b]) mmem[ad[m_win][5:2]][b*8 +: 8] = wd[m_win][b*8 +: 8];
            end
            if (m_win >= 0) begin
                if (lk[m_win]) m_next = m_win;
                else begin m_next = -1; m_rr = 1 - m_win; end
            end else begin
                m_next = -1;
                if (m_owner >= 0) m_rr = 1 - m_owner;
            end
            if (m_next != m_owner) m_held = 0;
            else if (m_owner >= 0 && m_held < LM) m_held++;
            m_owner = m_next;
        end
    end

    task automatic idle_inputs();
        m0_req = 0; m0_we = 0; m0_lock = 0; m0_be = '0; m0_addr = '0; m0_wdata = '0;
        m1_req = 0; m1_we = 0; m1_lock = 0; m1_be = '0; m1_addr = '0; m1_wdata = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_inputs();
        tick();
        tick();
        rst = 1'b0;
    endtask

    logic [6:0] s4_g0 = 7'b101_1111;
    logic [6:0] s4_g1 = 7'b010_0000;
    int cnt0, cnt1;

    // Directed scenarios with hand-computed expectations.
    initial begin
        // Scenario 1: simultaneous reads after reset.
        do_reset();
        m0_req = 1; m0_addr = 32'h0; m1_req = 1; m1_addr = 32'h4; #1;
        check("s1_c1_m0_gnt", m0_gnt, 1);
        check("s1_c1_m1_gnt", m1_gnt, 0);
        tick(); m0_req = 0; #1;
        check("s1_c2_m1_gnt", m1_gnt, 1);
        check("s1_c2_m0_rvalid", m0_rvalid, 1);
        check("s1_c2_m0_rdata", m0_rdata, 32'hA0A0_0000);
        tick(); m1_req = 0; #1;
        check("s1_c3_m1_rvalid", m1_rvalid, 1);
        check("s1_c3_m1_rdata", m1_rdata, 32'hA0A0_0001);
        check("s1_c3_m0_rvalid", m0_rvalid, 0);
        tick();

        // Scenario 2: partial write by m1, read back by m0.
        do_reset();
        m1_req = 1; m1_we = 1; m1_be = 4'b0011; m1_addr = 32'h8; m1_wdata = 32'hDEAD_BEEF; #1;
        check("s2_wr_m1_gnt", m1_gnt, 1);
        check("s2_wr_ram_we", ram_we, 1);
        tick(); m1_req = 0; m1_we = 0; m0_req = 1; m0_addr = 32'h8; #1;
        check("s2_rd_m0_gnt", m0_gnt, 1);
        check("s2_rd_m1_rvalid", m1_rvalid, 0);
        tick(); m0_req = 0; #1;
        check("s2_m0_rvalid", m0_rvalid, 1);
        check("s2_m0_rdata", m0_rdata, 32'hA0A0_BEEF);
        check("s2_m1_rvalid", m1_rvalid, 0);
        tick();

        // Scenario 3: locked burst of 4 reads while m1 waits.
        do_reset();
        m1_req = 1; m1_addr = 32'hC; m0_req = 1;
        for (int i = 0; i < 4; i++) begin
            m0_addr = 32'(16 + 4 * i); m0_lock = (i < 3); #1;
            check("s3_burst_m0_gnt", m0_gnt, 1);
            check("s3_burst_m1_gnt", m1_gnt, 0);
            tick();
        end
        m0_req = 0; m0_lock = 0; #1;
        check("s3_after_m1_gnt", m1_gnt, 1);
        tick(); m1_req = 0; tick(); tick();

        // Scenario 4: lock budget expires while m1 waits.
        do_reset();
        m0_req = 1; m0_lock = 1; m0_addr = 32'h0; m1_req = 1; m1_addr = 32'h4;
        for (int i = 0; i < 7; i++) begin
            #1;
            check("s4_m0_gnt", m0_gnt, s4_g0[i]);
            check("s4_m1_gnt", m1_gnt, s4_g1[i]);
            tick();
        end
        m0_req = 0; m0_lock = 0; m1_req = 0; tick(); tick();

        // Scenario 5: reset right after an accepted read, plus a read during reset.
        do_reset();
        m0_req = 1; m0_addr = 32'h4; #1;
        check("s5_m0_gnt", m0_gnt, 1);
        tick(); rst = 1; #1;
        check("s5_rvalid_before_rst", m0_rvalid, 1);
        tick(); rst = 0; m1_req = 1; m1_addr = 32'h8; #1;
        check("s5_m0_rvalid_after_rst", m0_rvalid, 0);
        check("s5_m1_rvalid_after_rst", m1_rvalid, 0);
        check("s5_rr0_m0_gnt", m0_gnt, 1);
        check("s5_rr0_m1_gnt", m1_gnt, 0);
        tick(); m0_req = 0; m1_req = 0; tick(); tick();

        // Scenario 6: continuous unlocked reads from both masters.
        do_reset();
        m0_req = 1; m1_req = 1; m0_addr = 32'h0; m1_addr = 32'h4;
        cnt0 = 0; cnt1 = 0;
        for (int i = 0; i < 12; i++) begin
            if (i == 10) begin m0_req = 0; m1_req = 0; end
            #1;
            if (i < 10) begin
                check("s6_m0_gnt", m0_gnt, (i % 2) == 0);
                check("s6_m1_gnt", m1_gnt, (i % 2) == 1);
            end
            cnt0 += int'(m0_rvalid);
            cnt1 += int'(m1_rvalid);
            tick();
        end
        check("s6_m0_rvalid_count", cnt0, 5);
        check("s6_m1_rvalid_count", cnt1, 5);
        check("s6_total_rvalid_count", cnt0 + cnt1, 10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Time bound for the whole run.
    initial begin
        #100000;
        failures++;
        $display("FAIL watchdog at %0t: actual=timeout required=finish", $time);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

endmodule
